// File: rtl/enigma_pkg.sv
// Shared plugboard types: letter code, alphabet size, pair limit, error codes, controller states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  localparam int      NUM_LETTERS   = 26;
  localparam letter_t LAST_LETTER   = 5'd25;
  localparam int      MAX_PAIRS_DEF = 13;

  localparam logic [1:0] ERR_BAD_LETTER = 2'd0;
  localparam logic [1:0] ERR_SELF_PAIR  = 2'd1;
  localparam logic [1:0] ERR_PLUGGED    = 2'd2;
  localparam logic [1:0] ERR_FULL       = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CLEAR = 2'd2
  } state_t;

  function automatic logic is_letter(input letter_t l);
    return l <= LAST_LETTER;
  endfunction

endpackage

// File: rtl/plugboard_pair_checker.sv
// Validates a candidate swap pair against the current map and pair count.
// Latency: purely combinational.
// Backpressure: none; the caller decides when err/err_code are consumed.
// Ports: pair_a/pair_b candidate letters, map_a/map_b current map entries for
// those letters (letter itself when out of range), pair_count committed pairs,
// err high when the pair must be rejected, err_code the highest-priority reason.
module plugboard_pair_checker
  import enigma_pkg::*;
#(
  parameter int MAX_PAIRS = MAX_PAIRS_DEF
) (
  input  letter_t    pair_a,
  input  letter_t    pair_b,
  input  letter_t    map_a,
  input  letter_t    map_b,
  input  logic [3:0] pair_count,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_PAIRS);

  // Ordered so that the most fundamental problem wins when several apply.
  always_comb begin
    err      = 1'b1;
    err_code = ERR_BAD_LETTER;
    if (!is_letter(pair_a) || !is_letter(pair_b)) begin
      err_code = ERR_BAD_LETTER;
    end else if (pair_a == pair_b) begin
      err_code = ERR_SELF_PAIR;
    end else if ((map_a != pair_a) || (map_b != pair_b)) begin
      err_code = ERR_PLUGGED;
    end else if (pair_count == MAX_CNT) begin
      err_code = ERR_FULL;
    end else begin
      err = 1'b0;
    end
  end

endmodule

// File: rtl/plugboard_config_ctrl.sv
// Plugboard map controller: swap-pair writes, letter lookups and a walking clear.
// Latency: lookup result 1 cycle after accept; pair ack/err 2 cycles after accept; clear 26 cycles.
// Backpressure: lk_ready only in IDLE; pair_ready in IDLE when no lookup competes; none while busy.
// Ports: clk/rst (async high), clr_req restore identity, pair_valid/pair_a/pair_b
// with pair_ready, pair_ack, pair_err, err_code; lk_valid/lk_in with lk_ready,
// out_valid, out_letter; pair_count committed pairs; busy high in CHECK/CLEAR.
module plugboard_config_ctrl
  import enigma_pkg::*;
#(
  parameter int MAX_PAIRS = MAX_PAIRS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_req,
  input  logic       pair_valid,
  input  letter_t    pair_a,
  input  letter_t    pair_b,
  output logic       pair_ready,
  output logic       pair_ack,
  output logic       pair_err,
  output logic [1:0] err_code,
  input  logic       lk_valid,
  input  letter_t    lk_in,
  output logic       lk_ready,
  output logic       out_valid,
  output letter_t    out_letter,
  output logic [3:0] pair_count,
  output logic       busy
);

  state_t  state, state_nxt;
  letter_t map_q [NUM_LETTERS];
  letter_t pa_q, pb_q;
  letter_t clr_idx;
  letter_t map_a, map_b;
  logic    chk_err;
  logic [1:0] chk_code;
  logic    lk_acc, pair_acc, commit, reject;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pair_ready = 1'b0;
    lk_ready   = 1'b0;
    case (state)
      IDLE: begin
        lk_ready   = 1'b1;
        // A same-cycle lookup wins; the pair waits one cycle.
        pair_ready = !lk_valid;
        if (pair_valid && !lk_valid) state_nxt = CHECK;
      end
      CHECK:   state_nxt = IDLE;
      CLEAR:   if (clr_idx == LAST_LETTER) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Clear overrides everything, including restarting a walk already in progress.
    if (clr_req) state_nxt = CLEAR;
  end

  assign busy     = (state != IDLE);
  assign lk_acc   = lk_valid && lk_ready;
  assign pair_acc = pair_valid && pair_ready;
  assign commit   = (state == CHECK) && !clr_req && !chk_err;
  assign reject   = (state == CHECK) && !clr_req && chk_err;

  // Out-of-range letters never index the map; they read back as themselves.
  assign map_a = is_letter(pa_q) ? map_q[pa_q] : pa_q;
  assign map_b = is_letter(pb_q) ? map_q[pb_q] : pb_q;

  plugboard_pair_checker #(.MAX_PAIRS(MAX_PAIRS)) u_checker (
    .pair_a     (pa_q),
    .pair_b     (pb_q),
    .map_a      (map_a),
    .map_b      (map_b),
    .pair_count (pair_count),
    .err        (chk_err),
    .err_code   (chk_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LETTERS; i++) map_q[i] <= letter_t'(i);
    end else if (state == CLEAR) begin
      map_q[clr_idx] <= clr_idx;
    end else if (commit) begin
      map_q[pa_q] <= pb_q;
      map_q[pb_q] <= pa_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_q       <= '0;
      pb_q       <= '0;
      clr_idx    <= '0;
      pair_count <= '0;
      pair_ack   <= 1'b0;
      pair_err   <= 1'b0;
      err_code   <= '0;
      out_valid  <= 1'b0;
      out_letter <= '0;
    end else begin
      pair_ack  <= commit;
      pair_err  <= reject;
      out_valid <= lk_acc;
      if (reject) err_code <= chk_code;
      if (pair_acc) begin
        pa_q <= pair_a;
        pb_q <= pair_b;
      end
      // Lookups accepted alongside a clear request still see the old map.
      if (lk_acc) out_letter <= is_letter(lk_in) ? map_q[lk_in] : lk_in;
      if (clr_req) begin
        clr_idx    <= '0;
        pair_count <= '0;
      end else begin
        if (state == CLEAR) clr_idx <= clr_idx + 5'd1;
        if (commit) pair_count <= pair_count + 4'd1;
      end
    end
  end

endmodule
